// File: rtl/ss_accum_mc.sv
// Multi-channel moving-average accumulator for stochastic bitstreams, with a periodic snapshot bank.
// Optional sticky saturation flags are enabled by defining SS_ACCUM_MC_SATFLAG_EN.
module ss_accum_mc #(
  parameter int C      = 4,
  parameter int N      = 16,
  parameter int DW     = 8,
  parameter int WINDOW = 256
) (
  input  logic           clk_i,
  input  logic           init_n_i,
  input  logic           en_i,
  input  logic           load_i,
  input  logic [N-1:0]   initial_avg_i,
  input  logic [DW-1:0]  decay_time_i,
  input  logic [C-1:0]   in_i,
  output logic [C*N-1:0] avg_o,
  output logic [C*N-1:0] snap_o,
`ifdef SS_ACCUM_MC_SATFLAG_EN
  output logic [C-1:0]   sat_hi_o,
  output logic [C-1:0]   sat_lo_o,
`endif
  output logic           snap_valid_o
);

  localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  logic [N-1:0]   avg_q [C];
  logic [N-1:0]   avg_d [C];
  logic [DW-1:0]  cnt_q [C];
  logic [DW-1:0]  cnt_d [C];
  logic [C-1:0]   inc_sat;
  logic [C-1:0]   dec_sat;
  logic [C*N-1:0] snap_q;
  logic [C*N-1:0] snap_d;
  logic [WW-1:0]  wcnt_q;
  logic           snap_valid_q;
  logic           wrap;

  // Per-channel next state; a saturated step still clears the decay counter.
  always_comb begin
    for (int i = 0; i < C; i++) begin
      avg_d[i]   = avg_q[i];
      cnt_d[i]   = cnt_q[i];
      inc_sat[i] = 1'b0;
      dec_sat[i] = 1'b0;
      if (in_i[i]) begin
        cnt_d[i] = '0;
        if (avg_q[i] == {N{1'b1}}) inc_sat[i] = 1'b1;
        else                       avg_d[i]   = avg_q[i] + N'(1);
      end else if (cnt_q[i] == decay_time_i) begin
        cnt_d[i] = '0;
        if (avg_q[i] == '0) dec_sat[i] = 1'b1;
        else                avg_d[i]   = avg_q[i] - N'(1);
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  always_comb begin
    avg_o  = '0;
    snap_d = '0;
    for (int i = 0; i < C; i++) begin
      avg_o[i*N +: N]  = avg_q[i];
      snap_d[i*N +: N] = avg_d[i];
    end
  end

  assign wrap = (wcnt_q == WW'(WINDOW - 1));

  always_ff @(posedge clk_i) begin
    if (!init_n_i) begin
      for (int i = 0; i < C; i++) begin
        avg_q[i] <= initial_avg_i;
        cnt_q[i] <= '0;
      end
      wcnt_q       <= '0;
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else if (load_i) begin
      for (int i = 0; i < C; i++) begin
        avg_q[i] <= initial_avg_i;
        cnt_q[i] <= '0;
      end
      wcnt_q       <= '0;
      snap_valid_q <= 1'b0;
    end else if (!en_i) begin
      snap_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < C; i++) begin
        avg_q[i] <= avg_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      wcnt_q       <= wrap ? '0 : wcnt_q + WW'(1);
      snap_valid_q <= wrap;
      if (wrap) snap_q <= snap_d;
    end
  end

`ifdef SS_ACCUM_MC_SATFLAG_EN
  logic [C-1:0] sat_hi_q;
  logic [C-1:0] sat_lo_q;

  // Flags restart each window: cleared on the cycle following the snapshot pulse.
  always_ff @(posedge clk_i) begin
    if (!init_n_i || load_i) begin
      sat_hi_q <= '0;
      sat_lo_q <= '0;
    end else if (en_i) begin
      sat_hi_q <= (snap_valid_q ? '0 : sat_hi_q) | inc_sat;
      sat_lo_q <= (snap_valid_q ? '0 : sat_lo_q) | dec_sat;
    end
  end

  assign sat_hi_o = sat_hi_q;
  assign sat_lo_o = sat_lo_q;
`else
  logic unused_sat;
  assign unused_sat = ^{inc_sat, dec_sat};
`endif

  assign snap_o       = snap_q;
  assign snap_valid_o = snap_valid_q;

endmodule

// File: tb/tb_ss_accum_mc.sv
// Directed bench for ss_accum_mc with a 4-cycle snapshot window; expected values hand-computed.
module tb_ss_accum_mc;

  localparam int C = 4;
  localparam int N = 16;
  localparam int DW = 8;
  localparam int WINDOW = 4;

  logic           clk_i = 1'b0;
  logic           init_n_i;
  logic           en_i;
  logic           load_i;
  logic [N-1:0]   initial_avg_i;
  logic [DW-1:0]  decay_time_i;
  logic [C-1:0]   in_i;
  logic [C*N-1:0] avg_o;
  logic [C*N-1:0] snap_o;
  logic           snap_valid_o;

  int tests_run = 0;
  int tests_failed = 0;

  ss_accum_mc #(.C(C), .N(N), .DW(DW), .WINDOW(WINDOW)) dut (
    .clk_i         (clk_i),
    .init_n_i      (init_n_i),
    .en_i          (en_i),
    .load_i        (load_i),
    .initial_avg_i (initial_avg_i),
    .decay_time_i  (decay_time_i),
    .in_i          (in_i),
    .avg_o         (avg_o),
    .snap_o        (snap_o),
    .snap_valid_o  (snap_valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    init_n_i      = 1'b0;
    en_i          = 1'b1;
    load_i        = 1'b0;
    initial_avg_i = 16'h0100;
    decay_time_i  = 8'd3;
    in_i          = 4'b0000;

    // reset
    tick();
    check("rst_avg",  avg_o, {4{16'h0100}});
    check("rst_snap", snap_o, 64'h0);
    check("rst_sv",   {63'h0, snap_valid_o}, 64'h0);
    init_n_i = 1'b1;

    // decay with DECAY_TIME=3, all channels idle
    tick(); tick(); tick();
    check("decay_e3", avg_o[15:0], 16'h0100);
    tick();
    check("decay_e4",    avg_o[15:0], 16'h00FF);
    check("win_sv_e4",   {63'h0, snap_valid_o}, 64'h1);
    check("win_snap_e4", snap_o, {4{16'h00FF}});
    tick();
    check("win_sv_e5", {63'h0, snap_valid_o}, 64'h0);
    tick(); tick(); tick();
    check("decay_e8", avg_o[15:0], 16'h00FE);

    // saturate high after a reload
    initial_avg_i = 16'hFFFE;
    load_i = 1'b1;
    tick();
    check("load_avg",  avg_o, {4{16'hFFFE}});
    check("load_snap", snap_o, {4{16'h00FE}});
    check("load_sv",   {63'h0, snap_valid_o}, 64'h0);
    load_i = 1'b0;
    in_i = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sat_hi", avg_o, {4{16'hFFFF}});
    end

    // floor at zero with DECAY_TIME=0
    initial_avg_i = 16'h0000;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    in_i = 4'b0000;
    decay_time_i = 8'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("sat_lo", avg_o, 64'h0);
    end

    // window timing with IN=0101
    initial_avg_i = 16'h0010;
    decay_time_i = 8'hFF;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    in_i = 4'b0101;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("w5_nosv", {63'h0, snap_valid_o}, 64'h0);
    end
    tick();
    check("w5_sv4",   {63'h0, snap_valid_o}, 64'h1);
    check("w5_snap4", snap_o, {16'h0010, 16'h0014, 16'h0010, 16'h0014});
    tick(); tick(); tick(); tick();
    check("w5_sv8", {63'h0, snap_valid_o}, 64'h1);
    tick(); tick();
    en_i = 1'b0;
    tick();
    check("hold_sv", {63'h0, snap_valid_o}, 64'h0);
    tick();
    check("hold_avg", avg_o[15:0], 16'h001A);
    en_i = 1'b1;
    tick();
    check("delay_sv13", {63'h0, snap_valid_o}, 64'h0);
    tick();
    check("delay_sv14",   {63'h0, snap_valid_o}, 64'h1);
    check("delay_snap14", snap_o, {16'h0010, 16'h001C, 16'h0010, 16'h001C});

    // LOAD at wcnt=2 restarts the window and keeps SNAP
    tick(); tick();
    check("pre_load_avg", avg_o[15:0], 16'h001E);
    initial_avg_i = 16'h0040;
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
    check("mid_load_avg",  avg_o, {4{16'h0040}});
    check("mid_load_snap", snap_o, {16'h0010, 16'h001C, 16'h0010, 16'h001C});
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("post_load_nosv", {63'h0, snap_valid_o}, 64'h0);
    end
    tick();
    check("post_load_sv",   {63'h0, snap_valid_o}, 64'h1);
    check("post_load_snap", snap_o, {16'h0040, 16'h0044, 16'h0040, 16'h0044});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
